// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU among NREQ lanes
// Optional ALU_ARB_LANE0_PRIO_EN: lane 0 gets fixed top priority and does not move the pointer.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_srca,
  input  logic [NREQ*32-1:0]  req_srcb,
  input  logic [NREQ*5-1:0]   req_sa,
  input  logic [NREQ*4-1:0]   req_ctrl,
  output logic [31:0]         alu_srca,
  output logic [31:0]         alu_srcb,
  output logic [4:0]          alu_sa,
  output logic [3:0]          alu_ctrl,
  input  logic [31:0]         alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_result
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_result_q, rsp_result_d;

  logic           free;
  logic           grant;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   cand;

  // Search from ptr upward with wrap; the reset cycle never grants.
  always_comb begin
    free   = !rsp_valid_q || rsp_ready;
    grant  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    if (free && !reset) begin
`ifdef ALU_ARB_LANE0_PRIO_EN
      if (req_valid[0]) begin
        grant  = 1'b1;
        gnt_id = '0;
      end
`endif
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NREQ)) begin
          cand = cand - (IDW+1)'(NREQ);
        end
        if (!grant && req_valid[cand[IDW-1:0]]) begin
          grant  = 1'b1;
          gnt_id = cand[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = grant ? (NREQ'(1) << gnt_id) : '0;
    alu_srca  = grant ? req_srca[32*gnt_id +: 32] : '0;
    alu_srcb  = grant ? req_srcb[32*gnt_id +: 32] : '0;
    alu_sa    = grant ? req_sa[5*gnt_id +: 5]     : '0;
    alu_ctrl  = grant ? req_ctrl[4*gnt_id +: 4]   : '0;
  end

  always_comb begin
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    if (grant) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_id;
      rsp_result_d = alu_result;
`ifdef ALU_ARB_LANE0_PRIO_EN
      if (gnt_id != '0) begin
        ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
`else
      ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
`endif
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed bench for alu_share_arbiter
module tb_alu_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*32-1:0]  req_srca, req_srcb;
  logic [NREQ*5-1:0]   req_sa;
  logic [NREQ*4-1:0]   req_ctrl;
  logic [31:0]         alu_srca, alu_srcb, alu_result, rsp_result;
  logic [4:0]          alu_sa;
  logic [3:0]          alu_ctrl;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;

  logic        lv [NREQ];
  logic [31:0] la [NREQ];
  logic [31:0] lb [NREQ];
  logic [4:0]  ls [NREQ];
  logic [3:0]  lc [NREQ];
  logic [3:0]  codes [9] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};

  int n_chk = 0;
  int n_fail = 0;
  int m_ptr = 0;
  int m_id = 0;
  logic m_rv = 1'b0;
  logic [31:0] m_res = '0;
  logic [NREQ-1:0] last_rdy = '0;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_sa(req_sa), .req_ctrl(req_ctrl),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_sa(alu_sa), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sa, input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, $signed(a) < $signed(b)};
      4'b1000: return b << sa;
      4'b1001: return b >> sa;
      4'b1010: return $unsigned($signed(b) >>> sa);
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_srca, alu_srcb, alu_sa, alu_ctrl);

  always_comb begin
    req_valid = '0;
    req_srca  = '0;
    req_srcb  = '0;
    req_sa    = '0;
    req_ctrl  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = lv[i];
      req_srca[32*i +: 32] = la[i];
      req_srcb[32*i +: 32] = lb[i];
      req_sa[5*i +: 5]     = ls[i];
      req_ctrl[4*i +: 4]   = lc[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: grant the valid lane closest to the pointer (clockwise distance), one-slot queue.
  always @(negedge clk) begin
    int g;
    int best;
    int d;
    logic [31:0] exp_rdy;
    g = -1;
    best = NREQ;
    last_rdy = req_ready;
    if (!reset && (!m_rv || rsp_ready)) begin
`ifdef ALU_ARB_LANE0_PRIO_EN
      if (lv[0]) g = 0;
`endif
      if (g < 0) begin
        for (int i = 0; i < NREQ; i++) begin
          d = (i - m_ptr + NREQ) % NREQ;
          if (lv[i] && d < best) begin
            best = d;
            g = i;
          end
        end
      end
    end
    exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
    chk("m_req_ready", 32'(req_ready), exp_rdy);
    chk("m_alu_srca", alu_srca, (g >= 0) ? la[g] : 32'd0);
    chk("m_alu_srcb", alu_srcb, (g >= 0) ? lb[g] : 32'd0);
    chk("m_alu_sa_ctrl", {23'd0, alu_sa, alu_ctrl}, (g >= 0) ? {23'd0, ls[g], lc[g]} : 32'd0);
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
      chk("m_rsp_result", rsp_result, m_res);
    end
    if (reset) begin
      m_rv = 1'b0; m_id = 0; m_res = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_rv = 1'b1;
      m_id = g;
      m_res = alu_f(la[g], lb[g], ls[g], lc[g]);
`ifdef ALU_ARB_LANE0_PRIO_EN
      if (g != 0) m_ptr = (g + 1) % NREQ;
`else
      m_ptr = (g + 1) % NREQ;
`endif
    end else if (m_rv && rsp_ready) begin
      m_rv = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NREQ; i++) begin
      lv[i] = 1'b0; la[i] = '0; lb[i] = '0; ls[i] = '0; lc[i] = '0;
    end
  endtask

  task automatic rnd_lane(input int i);
    la[i] = $urandom;
    lb[i] = $urandom;
    ls[i] = 5'($urandom_range(0, 31));
    lc[i] = codes[$urandom_range(0, 8)];
  endtask

  task automatic refresh_granted();
    for (int i = 0; i < NREQ; i++) if (last_rdy[i]) rnd_lane(i);
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    clear_lanes();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_ord [6];
    clear_lanes();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) lv[i] = 1'b1;
    settle();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    cyc();
    reset = 1'b0;
    clear_lanes();

    // single request on lane 2: 5 + 3
    lv[2] = 1'b1; la[2] = 32'd5; lb[2] = 32'd3; lc[2] = 4'b0010;
    settle();
    chk("single_req_ready", 32'(req_ready), 32'h4);
    cyc();
    lv[2] = 1'b0;
    settle();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);
    chk("single_rsp_result", rsp_result, 32'd8);
    chk("single_ptr", 32'(dut.ptr_q), 32'd3);
    cyc();
    settle();
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);

    // all lanes continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) begin lv[i] = 1'b1; rnd_lane(i); end
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("rr_grant", 32'(req_ready), 32'd1 << (c % 4));
      chk("rr_rsp_valid", 32'(rsp_valid), (c > 0) ? 32'h1 : 32'h0);
      cyc();
      refresh_granted();
    end

    // back-pressure with lanes 0 and 1
    do_reset();
    rsp_ready = 1'b0;
    lv[0] = 1'b1; la[0] = 32'd10; lb[0] = 32'd20; lc[0] = 4'b0010;
    lv[1] = 1'b1; la[1] = 32'd7;  lb[1] = 32'd1;  lc[1] = 4'b0110;
    settle();
    chk("bp_first_grant", 32'(req_ready), 32'h1);
    cyc();
    lv[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_no_grant", 32'(req_ready), 32'h0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_id", 32'(rsp_id), 32'h0);
      chk("bp_hold_result", rsp_result, 32'd30);
      cyc();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_release_grant", 32'(req_ready), 32'h2);
    cyc();
    lv[1] = 1'b0;
    settle();
    chk("bp_next_id", 32'(rsp_id), 32'h1);
    chk("bp_next_result", rsp_result, 32'd6);

    // reset while a response is pending, then lanes 0 and 3
    cyc();
    for (int i = 0; i < NREQ; i++) begin lv[i] = 1'b1; rnd_lane(i); end
    cyc();
    refresh_granted();
    settle();
    chk("mid_pre_valid", 32'(rsp_valid), 32'h1);
    cyc();
    reset = 1'b1;
    settle();
    chk("mid_reset_no_grant", 32'(req_ready), 32'h0);
    cyc();
    reset = 1'b0;
    clear_lanes();
    lv[0] = 1'b1; rnd_lane(0);
    lv[3] = 1'b1; rnd_lane(3);
    settle();
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rsp_id", 32'(rsp_id), 32'h0);
    chk("mid_rsp_result", rsp_result, 32'h0);
`ifdef ALU_ARB_LANE0_PRIO_EN
    exp_ord = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
`else
    exp_ord = '{32'h1, 32'h8, 32'h1, 32'h8, 32'h1, 32'h8};
`endif
    for (int c = 0; c < 6; c++) begin
      chk("lane03_grant", 32'(req_ready), exp_ord[c]);
      cyc();
      refresh_granted();
      settle();
    end

    // arithmetic shift right passthrough on lane 1
    do_reset();
    lv[1] = 1'b1; lb[1] = 32'h8000_0000; ls[1] = 5'd4; lc[1] = 4'b1010;
    settle();
    chk("shift_grant", 32'(req_ready), 32'h2);
    chk("shift_alu_sa", 32'(alu_sa), 32'd4);
    chk("shift_alu_ctrl", 32'(alu_ctrl), 32'hA);
    cyc();
    lv[1] = 1'b0;
    settle();
    chk("shift_result", rsp_result, 32'hF800_0000);

    // randomized traffic, back-pressure and occasional reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (!lv[i] || last_rdy[i]) begin
          lv[i] = ($urandom_range(0, 2) != 0);
          rnd_lane(i);
        end
      end
    end
    cyc();
    reset = 1'b0;
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
